mem_stage: RTL and testbench



---
 rtl/mem_stage_pkg.sv | 57 +++++
 rtl/mem_stage_load_align.sv | 33 +++
 rtl/mem_stage.sv | 198 +++++++++++++++++++
 tb/tb_mem_stage.sv | 329 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_stage_pkg.sv
// Shared encodings and lane helpers for the MEM stage.
// Buses are held as [31:0]; byte lane 0 (address offset 0) is the most significant byte.
package mem_stage_pkg;

    localparam logic [1:0] DS_BYTE = 2'b00;
    localparam logic [1:0] DS_HALF = 2'b01;
    localparam logic [1:0] DS_WORD = 2'b10;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_e;

    localparam logic [1:0] LANE0 = 2'd0;
    localparam logic [1:0] LANE1 = 2'd1;
    localparam logic [1:0] LANE2 = 2'd2;
    localparam logic [1:0] LANE3 = 2'd3;

    function automatic logic is_aligned(input logic [1:0] dsize, input logic [1:0] offset);
        logic ok;
        case (dsize)
            DS_BYTE:       ok = 1'b1;
            DS_HALF:       ok = ~offset[0];
            DS_WORD, 2'b11: ok = (offset == LANE0);
        endcase
        return ok;
    endfunction

    // be[3] is lane 0, so enables read left-to-right in address order
    function automatic logic [3:0] byte_en(input logic [1:0] dsize, input logic [1:0] offset);
        logic [3:0] be;
        case (dsize)
            DS_BYTE: begin
                case (offset)
                    LANE0: be = 4'b1000;
                    LANE1: be = 4'b0100;
                    LANE2: be = 4'b0010;
                    LANE3: be = 4'b0001;
                endcase
            end
            DS_HALF:        be = offset[1] ? 4'b0011 : 4'b1100;
            DS_WORD, 2'b11: be = 4'b1111;
        endcase
        return be;
    endfunction

    function automatic logic [31:0] store_align(input logic [1:0] dsize, input logic [31:0] data);
        logic [31:0] w;
        case (dsize)
            DS_BYTE:        w = {4{data[7:0]}};
            DS_HALF:        w = {2{data[15:0]}};
            DS_WORD, 2'b11: w = data;
        endcase
        return w;
    endfunction

endpackage

// File: rtl/mem_stage_load_align.sv
// Picks the addressed lane(s) out of a big-endian read word and extends to 32 bits.
module load_align
    import mem_stage_pkg::*;
(
    input  logic [31:0] rdata_i,
    input  logic [1:0]  offset_i,
    input  logic [1:0]  dsize_i,
    input  logic        load_sign_i,
    output logic [31:0] data_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = rdata_i[31:24];
        case (offset_i)
            LANE0: byte_sel = rdata_i[31:24];
            LANE1: byte_sel = rdata_i[23:16];
            LANE2: byte_sel = rdata_i[15:8];
            LANE3: byte_sel = rdata_i[7:0];
        endcase
        half_sel = offset_i[1] ? rdata_i[15:0] : rdata_i[31:16];

        data_o = rdata_i;
        case (dsize_i)
            DS_BYTE:        data_o = {{24{load_sign_i & byte_sel[7]}}, byte_sel};
            DS_HALF:        data_o = {{16{load_sign_i & half_sel[15]}}, half_sel};
            DS_WORD, 2'b11: data_o = rdata_i;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: EX/MEM latch, data-memory req/ack sequencing and MEM/WB latch.
// stall_out freezes upstream while an access waits for dmem_ack.
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              valid_in,
    input  logic [31:0]       nextPC_in,
    input  logic [31:0]       aluResult_in,
    input  logic [31:0]       storeData_in,
    input  logic [4:0]        destReg_in,
    input  logic              PCtoReg_in,
    input  logic              RegWrite_in,
    input  logic              MemToReg_in,
    input  logic              MemWrite_in,
    input  logic              loadSign_in,
    input  logic [1:0]        DSize_in,
    output logic              stall_out,
    output logic              misalign_out,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic [3:0]        dmem_be,
    output logic [31:0]       dmem_wdata,
    input  logic              dmem_ack,
    input  logic [31:0]       dmem_rdata,
    output logic              wb_valid,
    output logic              wb_RegWrite,
    output logic [4:0]        wb_destReg,
    output logic [31:0]       wb_data
);

    state_e state_q, state_d;

    logic        valid_q;
    logic [31:0] nextpc_q;
    logic [31:0] alu_q;
    logic [4:0]  dest_q;
    logic        pctoreg_q;
    logic        regwrite_q;
    logic        memtoreg_q;
    logic        memwrite_q;
    logic        loadsign_q;
    logic [1:0]  dsize_q;

    logic              req_q, req_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [3:0]        be_q, be_d;
    logic [31:0]       wdata_q, wdata_d;

    logic        wb_valid_q, wb_valid_d;
    logic        wb_rw_q, wb_rw_d;
    logic [4:0]  wb_dest_q, wb_dest_d;
    logic [31:0] wb_data_q, wb_data_d;
    logic        misalign_q, misalign_d;

    logic        stall;
    logic        issue_in;
    logic        misaligned_q;
    logic [31:0] load_data;

    assign issue_in     = valid_in & (MemToReg_in | MemWrite_in)
                        & is_aligned(DSize_in, aluResult_in[1:0]);
    assign misaligned_q = valid_q & (memtoreg_q | memwrite_q)
                        & ~is_aligned(dsize_q, alu_q[1:0]);

    load_align u_load_align (
        .rdata_i     (dmem_rdata),
        .offset_i    (alu_q[1:0]),
        .dsize_i     (dsize_q),
        .load_sign_i (loadsign_q),
        .data_o      (load_data)
    );

    // Next request is decided from the EX inputs so dmem_req rises on the latching edge
    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        we_d    = we_q;
        addr_d  = addr_q;
        be_d    = be_q;
        wdata_d = wdata_q;
        stall   = 1'b0;

        case (state_q)
            ST_IDLE: stall = 1'b0;
            ST_BUSY: stall = ~dmem_ack;
            default: stall = 1'b0;
        endcase

        if (!stall) begin
            if (issue_in) begin
                state_d = ST_BUSY;
                req_d   = 1'b1;
                we_d    = MemWrite_in;
                addr_d  = {aluResult_in[ADDR_W-1:2], 2'b00};
                be_d    = byte_en(DSize_in, aluResult_in[1:0]);
                wdata_d = store_align(DSize_in, storeData_in);
            end else begin
                state_d = ST_IDLE;
                req_d   = 1'b0;
                we_d    = 1'b0;
                be_d    = 4'b0000;
            end
        end
    end

    // A stalled cycle sends a bubble so the waiting instruction reaches WB exactly once
    always_comb begin
        wb_valid_d = 1'b0;
        wb_rw_d    = 1'b0;
        misalign_d = 1'b0;
        wb_dest_d  = wb_dest_q;
        wb_data_d  = wb_data_q;

        if (!stall) begin
            wb_valid_d = valid_q;
            wb_rw_d    = valid_q & regwrite_q & ~misaligned_q;
            misalign_d = misaligned_q;
            wb_dest_d  = dest_q;
            if (pctoreg_q) begin
                wb_data_d = nextpc_q;
            end else if (memtoreg_q) begin
                wb_data_d = load_data;
            end else begin
                wb_data_d = alu_q;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            valid_q    <= 1'b0;
            nextpc_q   <= '0;
            alu_q      <= '0;
            dest_q     <= '0;
            pctoreg_q  <= 1'b0;
            regwrite_q <= 1'b0;
            memtoreg_q <= 1'b0;
            memwrite_q <= 1'b0;
            loadsign_q <= 1'b0;
            dsize_q    <= DS_BYTE;
            req_q      <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            be_q       <= '0;
            wdata_q    <= '0;
            wb_valid_q <= 1'b0;
            wb_rw_q    <= 1'b0;
            wb_dest_q  <= '0;
            wb_data_q  <= '0;
            misalign_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            req_q      <= req_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            be_q       <= be_d;
            wdata_q    <= wdata_d;
            wb_valid_q <= wb_valid_d;
            wb_rw_q    <= wb_rw_d;
            wb_dest_q  <= wb_dest_d;
            wb_data_q  <= wb_data_d;
            misalign_q <= misalign_d;
            if (!stall) begin
                valid_q    <= valid_in;
                nextpc_q   <= nextPC_in;
                alu_q      <= aluResult_in;
                dest_q     <= destReg_in;
                pctoreg_q  <= PCtoReg_in;
                regwrite_q <= RegWrite_in;
                memtoreg_q <= MemToReg_in;
                memwrite_q <= MemWrite_in;
                loadsign_q <= loadSign_in;
                dsize_q    <= DSize_in;
            end
        end
    end

    // storeData only matters at the latching edge, so it is never held in the EX/MEM latch
    assign stall_out    = stall;
    assign misalign_out = misalign_q;
    assign dmem_req     = req_q;
    assign dmem_we      = we_q;
    assign dmem_addr    = addr_q;
    assign dmem_be      = be_q;
    assign dmem_wdata   = wdata_q;
    assign wb_valid     = wb_valid_q;
    assign wb_RegWrite  = wb_rw_q;
    assign wb_destReg   = wb_dest_q;
    assign wb_data      = wb_data_q;

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: directed EX vectors, a memory responder and a WB monitor.
module tb_mem_stage;
    import mem_stage_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        valid_in = 1'b0;
    logic [31:0] nextPC_in = '0, aluResult_in = '0, storeData_in = '0;
    logic [4:0]  destReg_in = '0;
    logic        PCtoReg_in = 1'b0, RegWrite_in = 1'b0, MemToReg_in = 1'b0;
    logic        MemWrite_in = 1'b0, loadSign_in = 1'b0;
    logic [1:0]  DSize_in = DS_BYTE;
    logic        stall_out, misalign_out, dmem_req, dmem_we;
    logic [31:0] dmem_addr, dmem_wdata;
    logic [3:0]  dmem_be;
    logic        dmem_ack = 1'b0;
    logic [31:0] dmem_rdata = '0;
    logic        wb_valid, wb_RegWrite;
    logic [4:0]  wb_destReg;
    logic [31:0] wb_data;

    logic [31:0] la_rdata = '0, la_out;
    logic [1:0]  la_off = '0, la_ds = '0;
    logic        la_sign = 1'b0;

    mem_stage #(.ADDR_W(32)) dut (
        .clk(clk), .reset(reset), .valid_in(valid_in), .nextPC_in(nextPC_in),
        .aluResult_in(aluResult_in), .storeData_in(storeData_in), .destReg_in(destReg_in),
        .PCtoReg_in(PCtoReg_in), .RegWrite_in(RegWrite_in), .MemToReg_in(MemToReg_in),
        .MemWrite_in(MemWrite_in), .loadSign_in(loadSign_in), .DSize_in(DSize_in),
        .stall_out(stall_out), .misalign_out(misalign_out), .dmem_req(dmem_req),
        .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_be(dmem_be), .dmem_wdata(dmem_wdata),
        .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata), .wb_valid(wb_valid),
        .wb_RegWrite(wb_RegWrite), .wb_destReg(wb_destReg), .wb_data(wb_data)
    );

    load_align u_ref_align (
        .rdata_i(la_rdata), .offset_i(la_off), .dsize_i(la_ds),
        .load_sign_i(la_sign), .data_o(la_out)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        rw;
        logic [4:0]  dest;
        logic [31:0] data;
        logic        chk_data;
        logic        mis;
    } wb_exp_t;

    typedef struct packed {
        logic [31:0] addr;
        logic [3:0]  be;
        logic        we;
        logic [31:0] wdata;
        logic        chk_wdata;
        logic [7:0]  waits;
        logic [31:0] rdata;
    } mem_exp_t;

    wb_exp_t  exp_q[$];
    mem_exp_t mem_q[$];
    int       wb_cyc_q[$];

    int n_checks = 0, n_fail = 0;
    int cyc = 0, stall_cyc = 0, req_cyc = 0, mis_cyc = 0;
    int wait_left = 0;
    logic [31:0] cur_rdata = '0;
    logic prev_req = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Memory responder: acks after the programmed number of wait cycles
    initial begin
        mem_exp_t m;
        logic ack_was;
        forever begin
            @(posedge clk);
            #1;
            ack_was  = dmem_ack;
            dmem_ack = 1'b0;
            if (reset) begin
                prev_req  = 1'b0;
                wait_left = 0;
                continue;
            end
            if (dmem_req) begin
                if (!prev_req || ack_was) begin
                    if (mem_q.size() == 0) begin
                        chk("unexpected_req", {31'd0, dmem_req}, 32'd0);
                    end else begin
                        m = mem_q.pop_front();
                        chk("dmem_addr", dmem_addr, m.addr);
                        chk("dmem_be", {28'd0, dmem_be}, {28'd0, m.be});
                        chk("dmem_we", {31'd0, dmem_we}, {31'd0, m.we});
                        if (m.chk_wdata) chk("dmem_wdata", dmem_wdata, m.wdata);
                        wait_left = int'(m.waits);
                        cur_rdata = m.rdata;
                    end
                end
                if (wait_left == 0) begin
                    dmem_ack   = 1'b1;
                    dmem_rdata = cur_rdata;
                end else begin
                    wait_left--;
                end
            end
            prev_req = dmem_req;
        end
    end

    // WB monitor: pops the scoreboard whenever a valid slot reaches write-back
    initial begin
        wb_exp_t e;
        forever begin
            @(negedge clk);
            if (stall_out) stall_cyc++;
            if (dmem_req) req_cyc++;
            if (misalign_out) mis_cyc++;
            if (wb_valid) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_wb", {31'd0, wb_valid}, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    wb_cyc_q.push_back(cyc);
                    chk("wb_RegWrite", {31'd0, wb_RegWrite}, {31'd0, e.rw});
                    chk("wb_destReg", {27'd0, wb_destReg}, {27'd0, e.dest});
                    if (e.chk_data) chk("wb_data", wb_data, e.data);
                    chk("misalign_out", {31'd0, misalign_out}, {31'd0, e.mis});
                end
            end
        end
    end

    task automatic step();
        int n = 0;
        @(negedge clk);
        while (stall_out && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) chk("stall_timeout", 32'd1, 32'd0);
        @(posedge clk);
        #2;
    endtask

    task automatic send(input logic [31:0] npc, input logic [31:0] alu, input logic [31:0] sd,
                        input logic [4:0] dest, input logic pc2r, input logic rw,
                        input logic m2r, input logic mw, input logic sgn, input logic [1:0] ds);
        valid_in = 1'b1; nextPC_in = npc; aluResult_in = alu; storeData_in = sd;
        destReg_in = dest; PCtoReg_in = pc2r; RegWrite_in = rw; MemToReg_in = m2r;
        MemWrite_in = mw; loadSign_in = sgn; DSize_in = ds;
        step();
    endtask

    task automatic bubble();
        valid_in = 1'b0; RegWrite_in = 1'b0; MemToReg_in = 1'b0; MemWrite_in = 1'b0;
        PCtoReg_in = 1'b0;
        step();
    endtask

    task automatic drain();
        int n = 0;
        for (int i = 0; i < 3; i++) bubble();
        while ((exp_q.size() != 0 || mem_q.size() != 0) && n < 50) begin
            bubble();
            n++;
        end
        if (n >= 50) chk("drain_timeout", 32'd1, 32'd0);
    endtask

    task automatic exp_wb(input logic rw, input logic [4:0] dest, input logic [31:0] data,
                          input logic cd, input logic mis);
        wb_exp_t e;
        e.rw = rw; e.dest = dest; e.data = data; e.chk_data = cd; e.mis = mis;
        exp_q.push_back(e);
    endtask

    task automatic exp_mem(input logic [31:0] addr, input logic [3:0] be, input logic we,
                           input logic [31:0] wdata, input logic cw, input logic [7:0] waits,
                           input logic [31:0] rdata);
        mem_exp_t m;
        m.addr = addr; m.be = be; m.we = we; m.wdata = wdata; m.chk_wdata = cw;
        m.waits = waits; m.rdata = rdata;
        mem_q.push_back(m);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        #12;
        chk("rst_wb_valid", {31'd0, wb_valid}, 32'd0);
        chk("rst_wb_RegWrite", {31'd0, wb_RegWrite}, 32'd0);
        chk("rst_wb_destReg", {27'd0, wb_destReg}, 32'd0);
        chk("rst_wb_data", wb_data, 32'd0);
        chk("rst_dmem_req", {31'd0, dmem_req}, 32'd0);
        chk("rst_dmem_we", {31'd0, dmem_we}, 32'd0);
        chk("rst_dmem_be", {28'd0, dmem_be}, 32'd0);
        chk("rst_dmem_addr", dmem_addr, 32'd0);
        chk("rst_dmem_wdata", dmem_wdata, 32'd0);
        chk("rst_misalign", {31'd0, misalign_out}, 32'd0);
        chk("rst_stall", {31'd0, stall_out}, 32'd0);

        // standalone lane-extract vectors against hand values
        la_rdata = 32'h1180_2233; la_off = 2'd3; la_ds = DS_BYTE; la_sign = 1'b1; #1;
        chk("la_byte3", la_out, 32'h0000_0033);
        la_off = 2'd0; la_ds = DS_HALF; #1;
        chk("la_half0", la_out, 32'h0000_1180);
        la_rdata = 32'h8001_0000; #1;
        chk("la_half0_neg", la_out, 32'hFFFF_8001);
        la_ds = DS_WORD; la_off = 2'd0; #1;
        chk("la_word", la_out, 32'h8001_0000);

        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #2;

        // plain ALU op
        stall_cyc = 0; req_cyc = 0;
        exp_wb(1'b1, 5'd5, 32'h0000_0123, 1'b1, 1'b0);
        send(32'h4, 32'h0000_0123, 32'h0, 5'd5, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, DS_WORD);
        drain();
        chk("alu_stall_cycles", stall_cyc, 0);
        chk("alu_req_cycles", req_cyc, 0);

        // signed byte load, 3 wait cycles
        stall_cyc = 0;
        exp_mem(32'h100, 4'b0100, 1'b0, 32'h0, 1'b0, 8'd3, 32'h1180_2233);
        exp_wb(1'b1, 5'd7, 32'hFFFF_FF80, 1'b1, 1'b0);
        send(32'h8, 32'h101, 32'h0, 5'd7, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, DS_BYTE);
        drain();
        chk("lb_stall_cycles", stall_cyc, 3);

        // same access zero-extended
        exp_mem(32'h100, 4'b0100, 1'b0, 32'h0, 1'b0, 8'd0, 32'h1180_2233);
        exp_wb(1'b1, 5'd8, 32'h0000_0080, 1'b1, 1'b0);
        send(32'hC, 32'h101, 32'h0, 5'd8, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, DS_BYTE);
        drain();

        // half store, immediate ack
        stall_cyc = 0;
        exp_mem(32'h200, 4'b0011, 1'b1, 32'hBEEF_BEEF, 1'b1, 8'd0, 32'h0);
        exp_wb(1'b0, 5'd9, 32'h0000_0202, 1'b1, 1'b0);
        send(32'h10, 32'h202, 32'hDEAD_BEEF, 5'd9, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, DS_HALF);
        drain();
        chk("sh_stall_cycles", stall_cyc, 0);

        // misaligned word load
        stall_cyc = 0; req_cyc = 0; mis_cyc = 0;
        exp_wb(1'b0, 5'd10, 32'h0, 1'b0, 1'b1);
        exp_wb(1'b1, 5'd13, 32'h0000_0777, 1'b1, 1'b0);
        send(32'h14, 32'h0000_0006, 32'h0, 5'd10, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, DS_WORD);
        send(32'h18, 32'h0000_0777, 32'h0, 5'd13, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, DS_WORD);
        drain();
        chk("mis_req_cycles", req_cyc, 0);
        chk("mis_stall_cycles", stall_cyc, 0);
        chk("mis_pulse_cycles", mis_cyc, 1);

        // back-to-back loads, immediate ack
        stall_cyc = 0; req_cyc = 0;
        wb_cyc_q.delete();
        exp_mem(32'h300, 4'b1111, 1'b0, 32'h0, 1'b0, 8'd0, 32'hCAFE_F00D);
        exp_mem(32'h304, 4'b0011, 1'b0, 32'h0, 1'b0, 8'd0, 32'h1234_8001);
        exp_wb(1'b1, 5'd11, 32'hCAFE_F00D, 1'b1, 1'b0);
        exp_wb(1'b1, 5'd12, 32'hFFFF_8001, 1'b1, 1'b0);
        send(32'h1C, 32'h300, 32'h0, 5'd11, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, DS_WORD);
        send(32'h20, 32'h306, 32'h0, 5'd12, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, DS_HALF);
        chk("b2b_req_held", {31'd0, dmem_req}, 32'd1);
        chk("b2b_second_addr", dmem_addr, 32'h304);
        drain();
        chk("b2b_req_cycles", req_cyc, 2);
        chk("b2b_stall_cycles", stall_cyc, 0);
        if (wb_cyc_q.size() >= 2)
            chk("b2b_wb_consecutive", wb_cyc_q[1] - wb_cyc_q[0], 1);
        else
            chk("b2b_wb_count", wb_cyc_q.size(), 2);

        // link write
        exp_wb(1'b1, 5'd31, 32'h0000_0040, 1'b1, 1'b0);
        send(32'h40, 32'h999, 32'h0, 5'd31, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, DS_WORD);
        drain();

        // reset while BUSY
        exp_wb(1'b1, 5'd4, 32'h55, 1'b1, 1'b0);
        exp_mem(32'h400, 4'b1111, 1'b0, 32'h0, 1'b0, 8'd20, 32'h0);
        send(32'h44, 32'h55, 32'h0, 5'd4, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, DS_WORD);
        send(32'h48, 32'h400, 32'h0, 5'd6, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, DS_WORD);
        chk("busy_wb_valid", {31'd0, wb_valid}, 32'd1);
        chk("busy_req", {31'd0, dmem_req}, 32'd1);
        chk("busy_stall", {31'd0, stall_out}, 32'd1);
        #1;
        reset = 1'b1;
        exp_q.delete();
        mem_q.delete();
        valid_in = 1'b0; RegWrite_in = 1'b0; MemToReg_in = 1'b0;
        #1;
        chk("async_rst_req", {31'd0, dmem_req}, 32'd0);
        chk("async_rst_wb_valid", {31'd0, wb_valid}, 32'd0);
        chk("async_rst_stall", {31'd0, stall_out}, 32'd0);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #2;

        exp_wb(1'b1, 5'd3, 32'h0000_0077, 1'b1, 1'b0);
        send(32'h4C, 32'h77, 32'h0, 5'd3, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, DS_WORD);
        drain();
        chk("final_exp_empty", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
